// File: rtl/rnn_pkg.sv
// Shared constants for the rnn_matvec accelerator: register map, CTRL/STATUS
// bit positions, data_in field slices and the sequencer state encoding.
package rnn_pkg;

    localparam logic [31:0] ADDR_CTRL  = 32'd0;
    localparam logic [31:0] ADDR_VEC   = 32'd1;
    localparam logic [31:0] ADDR_MAT   = 32'd2;
    localparam logic [31:0] ADDR_BIAS  = 32'd3;
    localparam logic [31:0] ADDR_RPTR  = 32'd4;
    localparam logic [31:0] ADDR_RDATA = 32'd5;

    localparam int CTRL_START = 0;
    localparam int CTRL_RELU  = 1;
    localparam int CTRL_CLEAR = 2;

    localparam int IDX_HI     = 31;
    localparam int IDX_LO     = 16;
    localparam int MAT_ROW_HI = 31;
    localparam int MAT_ROW_LO = 24;
    localparam int MAT_COL_HI = 23;
    localparam int MAT_COL_LO = 16;
    localparam int PTR_HI     = 15;
    localparam int PTR_LO     = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_STORE,
        ST_DONE
    } state_t;

    // Index width for an array of n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rnn_mac.sv
// Signed multiply-accumulate: acc += a*b when en, synchronous clear wins over en.
module rnn_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 34
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;

    assign prod = a * b;

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/rnn_matvec.sv
// Bus-programmed fixed-point y = act(W*x + b): loads operands over a word bus,
// runs one MAC per cycle per row, saturates and optionally ReLU-clamps results.
module rnn_matvec
    import rnn_pkg::*;
#(
    parameter int ROWS   = 2,
    parameter int COLS   = 4,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    localparam int ROW_W = idx_w(ROWS);
    localparam int COL_W = idx_w(COLS);
    localparam int ACC_W = 2 * DATA_W + $clog2(COLS);
    localparam int SUM_W = ACC_W + 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    localparam logic signed [SUM_W-1:0]  SAT_MAX = SUM_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [SUM_W-1:0]  SAT_MIN = SUM_W'(-(2 ** (DATA_W - 1)));
    localparam logic signed [DATA_W-1:0] RES_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] RES_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] vec    [COLS];
    logic signed [DATA_W-1:0] mat    [ROWS][COLS];
    logic signed [DATA_W-1:0] bias   [ROWS];
    logic signed [DATA_W-1:0] result [ROWS];

    state_t           state, state_next;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             busy, relu_en, done, err;
    logic [15:0]      ptr;

    logic             mac_en, mac_clr;
    logic signed [ACC_W-1:0] acc;

    logic [15:0] vec_idx;
    logic [7:0]  mat_row, mat_col;
    logic        ctrl_wr, data_wr, idx_ok;
    logic        vec_we, mat_we, bias_we;
    logic        start_req, err_set;

    logic signed [ACC_W-1:0]  acc_shift;
    logic signed [SUM_W-1:0]  sum;
    logic signed [DATA_W-1:0] res_val;

    assign busy = (state == ST_MAC) || (state == ST_STORE);

    // Bus write decode; operand writes are refused while the engine is busy.
    // NOTE: every signal driven here gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        vec_idx   = data_in[IDX_HI:IDX_LO];
        mat_row   = data_in[MAT_ROW_HI:MAT_ROW_LO];
        mat_col   = data_in[MAT_COL_HI:MAT_COL_LO];
        ctrl_wr   = write && (addr == ADDR_CTRL);
        data_wr   = write && ((addr == ADDR_VEC) || (addr == ADDR_MAT) || (addr == ADDR_BIAS));
        idx_ok    = 1'b0;
        unique case (addr)
            ADDR_VEC:  idx_ok = 32'(vec_idx) < COLS;
            ADDR_MAT:  idx_ok = (32'(mat_row) < ROWS) && (32'(mat_col) < COLS);
            ADDR_BIAS: idx_ok = 32'(vec_idx) < ROWS;
            default:   idx_ok = 1'b0;
        endcase
        vec_we    = data_wr && !busy && idx_ok && (addr == ADDR_VEC);
        mat_we    = data_wr && !busy && idx_ok && (addr == ADDR_MAT);
        bias_we   = data_wr && !busy && idx_ok && (addr == ADDR_BIAS);
        err_set   = data_wr && (busy || !idx_ok);
        start_req = ctrl_wr && data_in[CTRL_START] && !busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mac_en     = (state == ST_MAC);
        mac_clr    = (state != ST_MAC);
        unique case (state)
            ST_IDLE:  if (start_req) state_next = ST_MAC;
            ST_MAC:   if (col == COL_LAST) state_next = ST_STORE;
            ST_STORE: state_next = (row == ROW_LAST) ? ST_DONE : ST_MAC;
            ST_DONE:  state_next = start_req ? ST_MAC : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (start_req) begin
            row <= '0;
            col <= '0;
        end else if (state == ST_MAC) begin
            col <= (col == COL_LAST) ? '0 : col + 1'b1;
        end else if (state == ST_STORE && row != ROW_LAST) begin
            row <= row + 1'b1;
        end
    end

    rnn_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (mat[row][col]),
        .b     (vec[col]),
        .acc   (acc)
    );

    // Rescale, add bias, saturate to the element range, then optional ReLU.
    always_comb begin
        acc_shift = acc >>> FRAC_W;
        sum       = SUM_W'(acc_shift) + SUM_W'(bias[row]);
        if (sum > SAT_MAX) begin
            res_val = RES_MAX;
        end else if (sum < SAT_MIN) begin
            res_val = RES_MIN;
        end else begin
            res_val = sum[DATA_W-1:0];
        end
        if (relu_en && res_val[DATA_W-1]) begin
            res_val = '0;
        end
    end

    // NOTE: operand and result arrays carry no reset; software loads them
    // before use, and leaving them unreset keeps them in plain RAM.
    always_ff @(posedge clk) begin
        if (vec_we) begin
            vec[vec_idx[COL_W-1:0]] <= data_in[DATA_W-1:0];
        end
        if (mat_we) begin
            mat[mat_row[ROW_W-1:0]][mat_col[COL_W-1:0]] <= data_in[DATA_W-1:0];
        end
        if (bias_we) begin
            bias[vec_idx[ROW_W-1:0]] <= data_in[DATA_W-1:0];
        end
        if (state == ST_STORE) begin
            result[row] <= res_val;
        end
    end

    // A new start clears done; the DONE state sets it; explicit clear loses to set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relu_en <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                relu_en <= data_in[CTRL_RELU];
            end
            if (start_req) begin
                done <= 1'b0;
            end else if (state == ST_DONE) begin
                done <= 1'b1;
            end else if (ctrl_wr && data_in[CTRL_CLEAR]) begin
                done <= 1'b0;
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (ctrl_wr && data_in[CTRL_CLEAR]) begin
                err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            data_out <= '0;
        end else begin
            if (write && addr == ADDR_RPTR) begin
                ptr <= data_in[PTR_HI:PTR_LO];
            end
            if (read) begin
                unique case (addr)
                    ADDR_CTRL:  data_out <= {29'b0, err, done, busy};
                    ADDR_RPTR:  data_out <= 32'(ptr);
                    ADDR_RDATA: begin
                        if (busy) begin
                            data_out <= '0;
                        end else begin
                            data_out <= (32'(ptr) < ROWS) ? 32'(result[ptr[ROW_W-1:0]]) : '0;
                            ptr      <= (32'(ptr) >= ROWS - 1) ? '0 : ptr + 16'd1;
                        end
                    end
                    default:    data_out <= '0;
                endcase
            end
        end
    end

endmodule
